// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional halt detection is enabled by defining the macro HALT_DETECT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_ir,
  output logic [31:0]      if_id_npc,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

`ifdef HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  localparam logic [5:0]       HLT_OP  = 6'b111111;
  localparam logic [31:0]      PC_STEP = 32'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;

  // Sequential address wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state selection: branch, then halt, then stall, then normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      pc_d    = {branch_target[31:2], 2'b00};
      ir_d    = 32'h0000_0000;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      ir_d    = imem_rdata;
      npc_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (HALT_EN && (imem_rdata[31:26] == HLT_OP)) begin
        state_d = ST_HALT;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_ir    = ir_q;
  assign if_id_npc   = npc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed table, corner sequences, random vs model.
module tb_if_stage;

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk1;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target, imem_rdata;
  logic [31:0] imem_addr, if_id_ir, if_id_npc;
  logic        if_id_valid, halted;
  logic [15:0] fetch_cnt;

  // Second instance: wrap-around reset PC and a tiny counter for saturation.
  logic        w_rst, w_stall, w_br;
  logic [31:0] w_target;
  logic [31:0] w_addr, w_ir, w_npc;
  logic        w_valid, w_halted;
  logic [2:0]  w_cnt;

  int checks = 0;
  int failures = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk1(clk1), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_cnt(fetch_cnt));

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(3)) u_wrap (
    .clk1(clk1), .rst(w_rst), .stall(w_stall), .branch_taken(w_br),
    .branch_target(w_target), .imem_addr(w_addr), .imem_rdata(imem_rdata),
    .if_id_ir(w_ir), .if_id_npc(w_npc), .if_id_valid(w_valid),
    .halted(w_halted), .fetch_cnt(w_cnt));

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk1);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_ir;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: the architectural view of the fetch stage.
  logic [31:0] m_pc, m_ir, m_npc;
  logic        m_valid, m_halt;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_npc = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [31:0] t,
                            input logic [31:0] rd);
    if (b) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_ir = 32'h0;
      m_valid = 1'b0;
      m_halt = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (!s) begin
      m_ir = rd;
      m_npc = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (HALT_EN && rd[31:26] == 6'b111111) m_halt = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_addr"}, imem_addr, m_pc);
    chk({tag, "_ir"}, if_id_ir, m_ir);
    chk({tag, "_npc"}, if_id_npc, m_npc);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(m_valid));
    chk({tag, "_halted"}, 32'(halted), 32'(m_halt));
    chk({tag, "_cnt"}, 32'(fetch_cnt), 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] rd, tg;
    logic        s, b;

    vecs[0] = '{1'b0, 1'b0, 32'h0, 32'h2001_000A, 32'h4,  32'h2001_000A, 32'h4, 1'b1, 16'd1};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h2002_0014, 32'h8,  32'h2002_0014, 32'h8, 1'b1, 16'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h8,  32'h2002_0014, 32'h8, 1'b1, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h8,  32'h2002_0014, 32'h8, 1'b1, 16'd2};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h8,  32'h2002_0014, 32'h8, 1'b1, 16'd2};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h1111_1111, 32'hC,  32'h1111_1111, 32'hC, 1'b1, 16'd3};
    vecs[6] = '{1'b1, 1'b1, 32'h43, 32'h5555_5555, 32'h40, 32'h0,        32'hC, 1'b0, 16'd3};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h2222_2222, 32'h44, 32'h2222_2222, 32'h44, 1'b1, 16'd4};

    rst = 1'b1; w_rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    w_stall = 1'b0; w_br = 1'b0; w_target = 32'h0;

    // Reset values appear before any clock edge.
    #2;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ir", if_id_ir, 32'h0);
    chk("rst_npc", if_id_npc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(fetch_cnt), 32'h0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    edge_step();
    rst = 1'b0;
    chk("first_addr", imem_addr, 32'h0);

    // Directed table: fetch, stall, branch+stall, resume.
    for (int i = 0; i < 8; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].target; imem_rdata = vecs[i].rdata;
      edge_step();
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_ir", i), if_id_ir, vecs[i].e_ir);
      chk($sformatf("vec%0d_npc", i), if_id_npc, vecs[i].e_npc);
      chk($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_cnt", i), 32'(fetch_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'h0);
    end
    stall = 1'b0; branch_taken = 1'b0;

    // HLT opcode fetch at PC 0x44.
    imem_rdata = 32'hFC00_0000;
    edge_step();
    chk("hlt_ir", if_id_ir, 32'hFC00_0000);
    chk("hlt_valid", 32'(if_id_valid), 32'h1);
    chk("hlt_addr", imem_addr, 32'h48);
    chk("hlt_cnt", 32'(fetch_cnt), 32'd5);
    chk("hlt_halted", 32'(halted), 32'(HALT_EN));
    stall = 1'b1;
    imem_rdata = 32'h3333_3333;
    edge_step();
    stall = 1'b0;
    edge_step();
    if (HALT_EN) begin
      chk("halt_hold_addr", imem_addr, 32'h48);
      chk("halt_hold_ir", if_id_ir, 32'hFC00_0000);
      chk("halt_hold_valid", 32'(if_id_valid), 32'h0);
      chk("halt_hold_cnt", 32'(fetch_cnt), 32'd5);
      chk("halt_hold_halted", 32'(halted), 32'h1);
    end else begin
      chk("nohalt_addr", imem_addr, 32'h4C);
      chk("nohalt_ir", if_id_ir, 32'h3333_3333);
      chk("nohalt_valid", 32'(if_id_valid), 32'h1);
      chk("nohalt_cnt", 32'(fetch_cnt), 32'd6);
      chk("nohalt_halted", 32'(halted), 32'h0);
    end

    // Asynchronous reset pulse away from the clock edge.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_halted", 32'(halted), 32'h0);
    chk("async_rst_cnt", 32'(fetch_cnt), 32'h0);
    chk("async_rst_valid", 32'(if_id_valid), 32'h0);
    rst = 1'b0;

    // Branch in the same cycle as an HLT fetch: branch wins.
    imem_rdata = 32'hFC00_0000; branch_taken = 1'b1; branch_target = 32'h0000_0101;
    edge_step();
    branch_taken = 1'b0;
    chk("brhlt_addr", imem_addr, 32'h100);
    chk("brhlt_halted", 32'(halted), 32'h0);
    chk("brhlt_valid", 32'(if_id_valid), 32'h0);
    chk("brhlt_ir", if_id_ir, 32'h0);
    chk("brhlt_cnt", 32'(fetch_cnt), 32'h0);

    // Wrap-around and counter saturation on the second instance.
    rst = 1'b1;
    imem_rdata = 32'h1234_5678;
    w_rst = 1'b0;
    edge_step();
    chk("wrap_npc", w_npc, 32'h0);
    chk("wrap_addr2", w_addr, 32'h0);
    chk("wrap_ir", w_ir, 32'h1234_5678);
    for (int n = 2; n <= 10; n++) begin
      edge_step();
      chk($sformatf("sat_cnt%0d", n), 32'(w_cnt), (n < 7) ? n : 7);
    end
    chk("wrap_addr_end", w_addr, 32'd36);
    w_rst = 1'b1;

    // Random traffic against the reference model.
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      s  = ($urandom % 4) == 0;
      b  = ($urandom % 10) == 0;
      tg = $urandom;
      rd = (($urandom % 8) == 0) ? {6'b111111, 26'($urandom)} : $urandom;
      stall = s; branch_taken = b; branch_target = tg; imem_rdata = rd;
      edge_step();
      model_edge(s, b, tg, rd);
      check_model($sformatf("rnd%0d", c));
      if (($urandom % 50) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model($sformatf("rndrst%0d", c));
        #1 rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the fetch counter.
REQ-003 SHALL have port clk1  input  1  the single pipeline clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold request from decode/hazard logic.
REQ-006 SHALL have port branch_taken  input  1  redirect request from the EX/MEM stage.
REQ-007 SHALL have port branch_target  input  32  redirect address.
REQ-008 SHALL have port imem_addr  output  32  instruction memory address (combinational from PC).
REQ-009 SHALL have port imem_rdata  input  32  instruction word, valid in the same cycle as imem_addr.
REQ-010 SHALL have port if_id_ir  output  32  IF/ID instruction register.
REQ-011 SHALL have port if_id_npc  output  32  IF/ID next-PC (fetch address + 4).
REQ-012 SHALL have port if_id_valid  output  1  the IF/ID contents are a live instruction.
REQ-013 SHALL have port halted  output  1  fetch frozen by a halt instruction.
REQ-014 SHALL have port fetch_cnt  output  CNT_W  count of instructions delivered to IF/ID.

Function
REQ-015 SHALL drive imem_addr = PC continuously, with no register stage.
REQ-016 SHALL, per edge, apply the first matching priority: branch_taken, then halted, then stall, then normal fetch.
REQ-017 On normal fetch, SHALL load if_id_ir<=imem_rdata, if_id_npc<=PC+4, if_id_valid<=1, PC<=PC+4, giving 1-cycle latency from address to IF/ID.
REQ-018 On branch_taken, SHALL load PC<=branch_target with bits [1:0] forced to 0, if_id_ir<=32'h0 (NOP), and if_id_valid<=0 (flush), even if stall or halted is asserted.
REQ-019 On stall without branch_taken, SHALL hold PC, if_id_ir, if_id_npc, and if_id_valid unchanged.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no error flag.
REQ-021 SHALL increment fetch_cnt on each normal fetch only, and SHALL saturate it at all-ones.
REQ-022 SHALL NOT count flushed slots, stalled cycles, or halted cycles in fetch_cnt.

Reset
REQ-023 On rst assertion, SHALL immediately set PC=RESET_PC, if_id_ir=0, if_id_npc=0, if_id_valid=0, halted=0, and fetch_cnt=0, independent of clk1.
REQ-024 SHALL perform its first normal fetch on the first clk1 rising edge after rst deasserts, from RESET_PC.
REQ-025 Reset mid-stall or mid-halt SHALL discard all state, and no pending branch SHALL survive.

Configuration
REQ-026 Macro HALT_DETECT_EN SHALL control halt detection.
REQ-027 With HALT_DETECT_EN defined, a normal fetch whose imem_rdata[31:26]==6'b111111 (HLT) SHALL latch into IF/ID with valid=1 and SHALL set halted=1 on the same edge.
REQ-028 With HALT_DETECT_EN defined and halted=1, SHALL freeze PC, hold if_id_ir, force if_id_valid<=0 from the next edge, and SHALL ignore stall.
REQ-029 With HALT_DETECT_EN defined, halted SHALL clear only on rst or branch_taken, and a branch_taken in the same cycle as the HLT fetch SHALL win, with halted staying 0.
REQ-030 Without HALT_DETECT_EN, halted SHALL be tied 0, and opcode 6'b111111 SHALL be fetched as an ordinary instruction.

Verification
REQ-031 Release rst and feed imem_rdata=32'h2001_000A then 32'h2002_0014 -> imem_addr 0, 4, 8; if_id_ir matches each word one edge later; if_id_npc 4, 8; fetch_cnt 2.
REQ-032 Assert stall for 3 edges at PC=8 -> PC, if_id_ir, and if_id_valid are unchanged for those 3 edges; fetch_cnt does not change; fetch resumes at 8.
REQ-033 Assert branch_taken with branch_target=32'h0000_0043 together with stall -> PC=32'h40, if_id_ir=0, if_id_valid=0 next edge; fetch at 32'h40 on the following edge.
REQ-034 Start with RESET_PC=32'hFFFF_FFFC -> first if_id_npc=0 and the second imem_addr=0.
REQ-035 With HALT_DETECT_EN defined, fetch 32'hFC00_0000 -> halted=1 and if_id_valid=1 for one edge, then 0; PC is frozen; fetch_cnt is frozen; pulsing rst restores PC=RESET_PC and halted=0.
REQ-036 Without HALT_DETECT_EN, fetch 32'hFC00_0000 -> halted stays 0, PC advances by 4, and fetch_cnt increments.
